aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Controller for the iterative AES encryption datapath.
- Arbitrates between two block requesters (A, B) with round-robin priority, then steps a shared round engine through initial AddRoundKey, NR-1 full rounds and the final round.
- Drives the round-key index into the external key-schedule mux and returns the ciphertext, tagged with the requester id, on a valid/ready output.
- The round logic (full round; final SubBytes/ShiftRows/AddRoundKey) stays external and combinational; this block owns the state register, the round counter and all handshakes.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- RKW, 4, width of rk_idx; must satisfy 2**RKW > NR.

Ports:
- clk  in  1  clock
- reset  in  1  reset (see Behaviour)
- a_valid  in  1  requester A has a plaintext block
- a_ready  out  1  block A accepted this cycle when high with a_valid
- a_data  in  128  requester A plaintext
- b_valid  in  1  requester B has a plaintext block
- b_ready  out  1  block B accepted this cycle when high with b_valid
- b_data  in  128  requester B plaintext
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext
- out_id  out  1  0 = block came from A, 1 = from B
- busy  out  1  high in every state except IDLE
- rk_idx  out  RKW  round-key index into the external schedule; 0 = first key applied
- rk_data  in  128  round key selected by rk_idx (combinational from the schedule)
- dp_state  out  128  current state register, fed to the round logic
- dp_round_in  in  128  full-round result of dp_state with rk_data
- dp_final_in  in  128  final-round result of dp_state with rk_data

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All registers are cleared on assertion.
- Reset values: FSM=IDLE, rk_idx=0, state=0, out_valid=0, out_id=0, busy=0, last_id=1 (so A wins the first tie).
- Reset mid-operation drops the in-flight block; no out_valid is produced for it.
- Arbitration is combinational and active only in IDLE:
  - grant A if a_valid && (!b_valid || last_id==1);
  - grant B if b_valid && (!a_valid || last_id==0).
  - a_ready/b_ready = IDLE && grant; at most one is high. Both are 0 outside IDLE.
- IDLE: on an accept edge:
  - state <= granted data XOR rk_data (rk_idx is 0 in IDLE);
  - out_id and last_id <= granted id;
  - rk_idx <= 1; go to ROUND.
- ROUND: each edge, state <= dp_round_in and rk_idx <= rk_idx+1. On the edge where rk_idx==NR-1, go to FINAL (rk_idx becomes NR).
- FINAL: one edge; state <= dp_final_in, out_valid <= 1; go to DONE.
- DONE:
  - out_data = state; out_data and out_id stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0, rk_idx <= 0, go to IDLE.
  - No new block is accepted in the same cycle.
- Latency and throughput: out_valid rises exactly NR clocks after the accept edge. Minimum spacing between accepts is NR+2 clocks.
- dp_state always equals the state register. rk_idx never exceeds NR.
- Inputs a_data/b_data are sampled only on the accept edge; the requester may change them afterwards.
- A requester that drops valid before being granted is simply not served; the block has no memory of the abandoned request.
- Simultaneous requests: requesters alternate strictly (A,B,A,B...) while both are held valid.

Decomposition:
- Shared package aes_pkg: AES_NR_128=10, AES_NR_192=12, AES_NR_256=14, block width 128, FSM state enum {IDLE, ROUND, FINAL, DONE}.
- One natural sub-module: aes_rr_arb2, a 2-input round-robin arbiter holding last_id, with inputs (valid_a, valid_b, enable, advance) and outputs (grant_a, grant_b, grant_id).

Test Plan:
- NR=10, bench drives a behavioural key schedule and round model with key 000102..0f; A sends 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_id=0, out_valid rises 10 clocks after the accept.
- NR=14, key 000102..1f, same plaintext on B -> 8ea2b7ca516745bfeafc49904b496089, out_id=1, latency 14.
- A and B held valid for 4 blocks each -> acceptance order A,B,A,B,...; a_ready and b_ready never high together; accepts spaced 12 clocks at NR=10 with out_ready tied high.
- Backpressure: out_ready held low for 20 clocks after out_valid -> out_data/out_id stable, a_ready/b_ready stay 0, busy=1; release -> IDLE on the next edge.
- Reset asserted during ROUND at rk_idx=5 -> immediately out_valid=0, busy=0, rk_idx=0; the next A block encrypts correctly and A wins the first tie.
- Only B valid repeatedly -> B served every time despite last_id=1; rk_idx sequence 0,1..10,0 per block.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Brief    : Shared AES constants and the round-sequencer state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Round counts for the three AES key sizes
  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  // Width of one AES block
  localparam int BLOCK_W = 128;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : aes_rr_arb2
//  Brief    : Two-input round-robin arbiter. The requester that did not win
//             the last accepted grant wins the next tie. last_id resets to 1
//             so that requester A wins the first tie.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic valid_a_i,
  input  logic valid_b_i,
  input  logic enable_i,
  input  logic advance_i,
  output logic grant_a_o,
  output logic grant_b_o,
  output logic grant_id_o
);

  logic last_id_q;

  // Grants are purely combinational; enable gates both so nothing is granted
  // while the owner is busy.
  assign grant_a_o  = enable_i & valid_a_i & (~valid_b_i | last_id_q);
  assign grant_b_o  = enable_i & valid_b_i & (~valid_a_i | ~last_id_q);
  assign grant_id_o = grant_b_o;

  // Remember which requester was served on each accepted grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_id_q <= 1'b1;
    end else if (advance_i) begin
      last_id_q <= grant_id_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_sequencer
//  Brief    : Controller for an iterative AES encryption datapath. Picks a
//             block from requester A or B (round-robin), applies the initial
//             AddRoundKey, steps NR-1 full rounds and the final round through
//             the external round logic, then returns the ciphertext tagged
//             with the requester id on a valid/ready output.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR  = AES_NR_128,
  parameter int RKW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_valid_i,
  output logic               a_ready_o,
  input  logic [BLOCK_W-1:0] a_data_i,
  input  logic               b_valid_i,
  output logic               b_ready_o,
  input  logic [BLOCK_W-1:0] b_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BLOCK_W-1:0] out_data_o,
  output logic               out_id_o,
  output logic               busy_o,
  output logic [RKW-1:0]     rk_idx_o,
  input  logic [BLOCK_W-1:0] rk_data_i,
  output logic [BLOCK_W-1:0] dp_state_o,
  input  logic [BLOCK_W-1:0] dp_round_in_i,
  input  logic [BLOCK_W-1:0] dp_final_in_i
);

  // Index of the last full round; the edge leaving it enters FINAL
  localparam logic [RKW-1:0] RK_LAST_ROUND = RKW'(NR - 1);
  localparam logic [RKW-1:0] RK_ONE        = RKW'(1);

  seq_state_e         fsm_q;
  logic [BLOCK_W-1:0] state_q;
  logic [RKW-1:0]     rk_idx_q;
  logic               out_valid_q;
  logic               out_id_q;
  logic               busy_q;

  logic               grant_a;
  logic               grant_b;
  logic               grant_id;
  logic               accept;
  logic [BLOCK_W-1:0] in_data;

  aes_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .valid_a_i  (a_valid_i),
    .valid_b_i  (b_valid_i),
    .enable_i   (fsm_q == IDLE),
    .advance_i  (accept),
    .grant_a_o  (grant_a),
    .grant_b_o  (grant_b),
    .grant_id_o (grant_id)
  );

  // A grant already implies the matching valid, so a grant is an accept
  assign accept  = grant_a | grant_b;
  assign in_data = grant_b ? b_data_i : a_data_i;

  // Sequencer: state register, round counter and output handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            // rk_idx is 0 here, so rk_data is the first round key
            state_q  <= in_data ^ rk_data_i;
            out_id_q <= grant_id;
            rk_idx_q <= RK_ONE;
            busy_q   <= 1'b1;
            fsm_q    <= ROUND;
          end
        end
        ROUND: begin
          state_q  <= dp_round_in_i;
          rk_idx_q <= rk_idx_q + RK_ONE;
          if (rk_idx_q == RK_LAST_ROUND) begin
            fsm_q <= FINAL;
          end
        end
        FINAL: begin
          state_q     <= dp_final_in_i;
          out_valid_q <= 1'b1;
          fsm_q       <= DONE;
        end
        DONE: begin
          // out_valid is always high here; hold everything until taken
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            rk_idx_q    <= '0;
            busy_q      <= 1'b0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign a_ready_o   = grant_a;
  assign b_ready_o   = grant_b;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = state_q;
  assign out_id_o    = out_id_q;
  assign busy_o      = busy_q;
  assign rk_idx_o    = rk_idx_q;
  assign dp_state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_sequencer
//  Brief    : Bench for aes_round_sequencer with a behavioural AES key
//             schedule and round logic; NR=10 and NR=14 instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- NR=10 instance ----------------
  logic         a_valid, a_ready, b_valid, b_ready, out_valid, out_ready, out_id, busy;
  logic [127:0] a_data, b_data, out_data, rk_data, dp_state, dp_round, dp_final;
  logic [3:0]   rk_idx;

  // ---------------- NR=14 instance ----------------
  logic         a_valid14, a_ready14, b_valid14, b_ready14, out_valid14, out_ready14, out_id14, busy14;
  logic [127:0] a_data14, b_data14, out_data14, rk_data14, dp_state14, dp_round14, dp_final14;
  logic [3:0]   rk_idx14;

  logic [127:0] rk10 [0:10];
  logic [127:0] rk14 [0:14];
  logic [31:0]  w    [0:59];

  aes_round_sequencer #(.NR(10), .RKW(4)) u_dut10 (
    .clk(clk), .reset(reset),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_id_o(out_id), .busy_o(busy), .rk_idx_o(rk_idx), .rk_data_i(rk_data),
    .dp_state_o(dp_state), .dp_round_in_i(dp_round), .dp_final_in_i(dp_final)
  );

  aes_round_sequencer #(.NR(14), .RKW(4)) u_dut14 (
    .clk(clk), .reset(reset),
    .a_valid_i(a_valid14), .a_ready_o(a_ready14), .a_data_i(a_data14),
    .b_valid_i(b_valid14), .b_ready_o(b_ready14), .b_data_i(b_data14),
    .out_valid_o(out_valid14), .out_ready_i(out_ready14), .out_data_o(out_data14),
    .out_id_o(out_id14), .busy_o(busy14), .rk_idx_o(rk_idx14), .rk_data_i(rk_data14),
    .dp_state_o(dp_state14), .dp_round_in_i(dp_round14), .dp_final_in_i(dp_final14)
  );

  // ---------------- behavioural AES ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, b;
    p = x; b = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      b = gmul(b, p);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mixcol(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
      o[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_full(input logic [127:0] s, input logic [127:0] k);
    return mixcol(sub_shift(s)) ^ k;
  endfunction

  function automatic logic [127:0] aes_fin(input logic [127:0] s, input logic [127:0] k);
    return sub_shift(s) ^ k;
  endfunction

  function automatic logic [127:0] ref10(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk10[0];
    for (int r = 1; r < 10; r++) s = aes_full(s, rk10[r]);
    return aes_fin(s, rk10[10]);
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  // External key-schedule mux and round logic
  always_comb rk_data   = (rk_idx   <= 4'd10) ? rk10[rk_idx]   : '0;
  always_comb rk_data14 = (rk_idx14 <= 4'd14) ? rk14[rk_idx14] : '0;
  assign dp_round   = aes_full(dp_state, rk_data);
  assign dp_final   = aes_fin(dp_state, rk_data);
  assign dp_round14 = aes_full(dp_state14, rk_data14);
  assign dp_final14 = aes_fin(dp_state14, rk_data14);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [127:0] d;
    logic         id;
  } exp_t;
  exp_t sb[$];
  int   acc_cyc = 0;
  logic prev_ov = 1'b0;

  // Scoreboard on the NR=10 instance: push at accept, pop at output handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      chk("ready_exclusive", {127'h0, a_ready & b_ready}, 128'h0);
      if (a_valid && a_ready) begin
        e.d = ref10(a_data); e.id = 1'b0; sb.push_back(e); acc_cyc = cyc + 1;
      end else if (b_valid && b_ready) begin
        e.d = ref10(b_data); e.id = 1'b1; sb.push_back(e); acc_cyc = cyc + 1;
      end
      if (out_valid && !prev_ov) chk("latency10", cyc - acc_cyc, 10);
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {127'h0, sb.size() > 0}, 128'h1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_id", out_id, e.id);
        end
      end
      prev_ov = out_valid;
    end
  end

  // Call at a falling edge; returns at the falling edge before the accept edge
  task automatic wait_acc(output logic id, output int at);
    int n = 0;
    id = 1'b0; at = -1;
    while (n < 60) begin
      if (a_valid && a_ready) begin id = 1'b0; at = cyc + 1; return; end
      if (b_valid && b_ready) begin id = 1'b1; at = cyc + 1; return; end
      @(negedge clk); n++;
    end
    chk("accept_timeout", n, 0);
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    chk("out_valid_seen", out_valid, 1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic         id, last_model, exp_id;
    int           at, prev_at, t0, n;
    logic [127:0] exp;

    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int k = 0; k <= 10; k++) rk10[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int k = 0; k <= 14; k++) rk14[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};

    a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; out_ready = 1;
    a_valid14 = 0; b_valid14 = 0; a_data14 = '0; b_data14 = '0; out_ready14 = 1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_state", dp_state, 0);
    chk("rst_state14", dp_state14, 0);
    reset = 0;
    last_model = 1'b1;

    // AES-128 known answer on A
    a_data = PT; a_valid = 1;
    @(negedge clk);
    wait_acc(id, at);
    chk("kat128_acc_id", id, 0);
    last_model = 1'b0;
    @(posedge clk); #1;
    a_valid = 0; a_data = rnd128();
    wait_ov();
    chk("kat128_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("kat128_id", out_id, 0);
    chk("kat128_rk_idx", rk_idx, 10);
    @(negedge clk);

    // AES-256 known answer on B of the NR=14 instance
    @(posedge clk); #1;
    b_data14 = PT; b_valid14 = 1;
    @(negedge clk);
    chk("kat256_b_ready", b_ready14, 1);
    t0 = cyc + 1;
    @(posedge clk); #1;
    b_valid14 = 0; b_data14 = rnd128();
    n = 0;
    while (!out_valid14 && n < 60) begin @(negedge clk); n++; end
    chk("kat256_latency", cyc - t0, 14);
    chk("kat256_data", out_data14, 128'h8ea2b7ca516745bfeafc49904b496089);
    chk("kat256_id", out_id14, 1);

    // Both requesters held valid: strict alternation, NR+2 spacing
    @(posedge clk); #1;
    a_data = rnd128(); b_data = rnd128(); a_valid = 1; b_valid = 1;
    @(negedge clk);
    prev_at = 0;
    for (int i = 0; i < 8; i++) begin
      wait_acc(id, at);
      exp_id = ~last_model;
      chk("rr_order", id, exp_id);
      last_model = id;
      if (i > 0) chk("rr_spacing", at - prev_at, 12);
      prev_at = at;
      @(posedge clk); #1;
      if (id) b_data = rnd128(); else a_data = rnd128();
      if (i == 7) begin a_valid = 0; b_valid = 0; end
      @(negedge clk);
    end
    repeat (14) @(negedge clk);

    // Backpressure on the output
    @(posedge clk); #1;
    out_ready = 0; a_data = rnd128(); exp = ref10(a_data); a_valid = 1;
    @(negedge clk);
    wait_acc(id, at);
    chk("bp_acc_id", id, 0);
    last_model = 1'b0;
    @(posedge clk); #1;
    b_valid = 1; a_data = rnd128();
    wait_ov();
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", out_data, exp);
      chk("bp_id", out_id, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_a_ready", a_ready, 0);
      chk("bp_b_ready", b_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0; out_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_rk", rk_idx, 0);

    // Reset during ROUND with an A block in flight (last_id would favour B)
    a_data = rnd128(); a_valid = 1;
    @(negedge clk);
    wait_acc(id, at);
    @(posedge clk); #1;
    a_valid = 0;
    n = 0;
    while (rk_idx != 4'd5 && n < 20) begin @(negedge clk); n++; end
    chk("mid_rk5", rk_idx, 5);
    reset = 1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rk_idx", rk_idx, 0);
    chk("mid_rst_state", dp_state, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 0;
    last_model = 1'b1;
    @(posedge clk); #1;
    a_data = rnd128(); b_data = rnd128(); a_valid = 1; b_valid = 1;
    @(negedge clk);
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 0);
    wait_acc(id, at);
    chk("post_rst_id", id, 0);
    last_model = 1'b0;
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    wait_ov();
    chk("post_rst_out_id", out_id, 0);
    @(negedge clk);

    // Only B requesting: served every time, rk_idx walks 1..NR then 0
    @(posedge clk); #1;
    b_data = rnd128(); b_valid = 1;
    @(negedge clk);
    for (int blk = 0; blk < 3; blk++) begin
      wait_acc(id, at);
      chk("onlyb_id", id, 1);
      chk("onlyb_rk_start", rk_idx, 0);
      @(posedge clk); #1;
      b_data = rnd128();
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        chk("onlyb_rk", rk_idx, k);
      end
      @(negedge clk);
      chk("onlyb_rk_done", rk_idx, 10);
      chk("onlyb_out_valid", out_valid, 1);
      @(negedge clk);
      chk("onlyb_rk_back", rk_idx, 0);
    end
    b_valid = 0;

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
